// File: rtl/i2c_slave_regs.sv
// I2C slave front end for the ADC register bank.
// Oversamples SCL/SDA on clk, decodes START/STOP, matches DEV_ADDR and
// serves pointer/write/read byte transactions onto a synchronous register
// port. SDA is only ever pulled low (sda_oe = 1) or released.
module i2c_slave_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h48,
  parameter int         NUM_REGS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       reg_wr_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
  } state_t;

  localparam logic [7:0] PTR_MASK   = 8'(NUM_REGS - 1);
  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

  // Synchronizer and edge-history flops (idle bus is high)
  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] tx_q, tx_d;
  logic       sda_oe_q, sda_oe_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wdata_q, wdata_d;
  logic       busy_q, busy_d;

  // Bus events derived from the synchronized lines
  logic       scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0] shift_in_s;
  logic [7:0] ptr_inc_s;
  logic       match_s, rw_s, ptr_ok_s;

  assign scl_rise_s = scl_sync_q & ~scl_hist_q;
  assign scl_fall_s = ~scl_sync_q & scl_hist_q;
  assign start_s    = scl_sync_q & sda_hist_q & ~sda_sync_q;
  assign stop_s     = scl_sync_q & ~sda_hist_q & sda_sync_q;
  assign shift_in_s = {sh_q[6:0], sda_sync_q};
  assign ptr_inc_s  = (ptr_q + 8'd1) & PTR_MASK;
  assign match_s    = (sh_q[7:1] == DEV_ADDR);
  assign rw_s       = sh_q[0];
  assign ptr_ok_s   = ({1'b0, sh_q} < NUM_REGS_W);

  assign sda_oe    = sda_oe_q;
  assign reg_wr_en = wr_en_q;
  assign reg_addr  = ptr_q;
  assign reg_wdata = wdata_q;
  assign busy      = busy_q;

  // State register plus all datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 4'd0;
      sh_q       <= 8'd0;
      ptr_q      <= 8'd0;
      tx_q       <= 8'd0;
      sda_oe_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      wdata_q    <= 8'd0;
      busy_q     <= 1'b0;
    end else begin
      scl_meta_q <= scl_in;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= sda_sync_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      ptr_q      <= ptr_d;
      tx_q       <= tx_d;
      sda_oe_q   <= sda_oe_d;
      wr_en_q    <= wr_en_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic: protocol sequencing, bit counting, shift and pointer
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    // The pointer advances the cycle after a write strobe
    if (wr_en_q) begin
      ptr_d = ptr_inc_s;
    end else begin
      ptr_d = ptr_q;
    end
    // START/STOP outrank any bit sampling in the same cycle
    if (start_s) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      sh_d      = 8'd0;
    end else if (stop_s) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise_s && (bit_cnt_q < 4'd8)) begin
            sh_d      = shift_in_s;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
            bit_cnt_d = 4'd0;
            if (state_q == S_ADDR) begin
              state_d = match_s ? S_ADDR_ACK : S_IDLE;
            end else if (state_q == S_PTR) begin
              if (ptr_ok_s) begin
                state_d = S_PTR_ACK;
                ptr_d   = sh_q;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              state_d = S_WDATA_ACK;
            end
          end else begin
            state_d = state_q;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall_s) begin
            bit_cnt_d = 4'd0;
            if (rw_s) begin
              state_d = S_RDATA;
              tx_d    = reg_rdata;
            end else begin
              state_d = S_PTR;
            end
          end else begin
            state_d = state_q;
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall_s) begin
            state_d   = S_WDATA;
            bit_cnt_d = 4'd0;
          end else begin
            state_d = state_q;
          end
        end
        S_RDATA: begin
          if (scl_rise_s && (bit_cnt_q < 4'd8)) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
            state_d   = S_RDATA_ACK;
            bit_cnt_d = 4'd0;
          end else begin
            state_d = state_q;
          end
        end
        S_RDATA_ACK: begin
          // bit_cnt = 1 marks a master ACK seen in this slot
          if (scl_rise_s) begin
            if (!sda_sync_q) begin
              ptr_d     = ptr_inc_s;
              bit_cnt_d = 4'd1;
            end else begin
              state_d = S_IDLE;
            end
          end else if (scl_fall_s && (bit_cnt_q == 4'd1)) begin
            state_d   = S_RDATA;
            bit_cnt_d = 4'd0;
            tx_d      = reg_rdata;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output logic: SDA pull-low enable, write strobe and busy flag
  always_comb begin
    sda_oe_d = sda_oe_q;
    wr_en_d  = 1'b0;
    wdata_d  = wdata_q;
    busy_d   = (state_d != S_IDLE);
    if (start_s || stop_s) begin
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
            sda_oe_d = match_s;
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        S_PTR: begin
          if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
            sda_oe_d = ptr_ok_s;
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        S_WDATA: begin
          if (scl_rise_s && (bit_cnt_q == 4'd7)) begin
            wr_en_d = 1'b1;
            wdata_d = shift_in_s;
          end else if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall_s) begin
            sda_oe_d = rw_s & ~reg_rdata[7];
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall_s) begin
            sda_oe_d = 1'b0;
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        S_RDATA: begin
          if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
            sda_oe_d = 1'b0;
          end else if (scl_fall_s && (bit_cnt_q != 4'd0)) begin
            sda_oe_d = ~tx_q[3'd7 - bit_cnt_q[2:0]];
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        S_RDATA_ACK: begin
          if (scl_fall_s && (bit_cnt_q == 4'd1)) begin
            sda_oe_d = ~reg_rdata[7];
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Self-checking bench for i2c_slave_regs: an open-drain bus master drives
// directed transactions; expected write strobes and slave-driven SDA bits
// are queued and checked by monitor threads as the DUT produces them.
module tb_i2c_slave_regs;

  localparam int Q = 50;  // quarter SCL period (5 clk)

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       sda_oe, reg_wr_en, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       slot_active, forbid_oe;

  int          checks, errors;
  logic [15:0] exp_wr[$];
  logic        exp_sda[$];

  assign sda_line  = sda_m & ~sda_oe;
  assign reg_rdata = reg_addr + 8'h40;

  i2c_slave_regs #(.DEV_ADDR(7'h48), .NUM_REGS(16)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line),
    .sda_oe(sda_oe), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .busy(busy)
  );

  // Free-running system clock
  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One SCL bit starting and ending mid-low
  task automatic sbit(input logic b, input logic slot);
    sda_m = b;
    slot_active = slot;
    #Q scl_m = 1'b1;
    #(2*Q) scl_m = 1'b0;
    #Q slot_active = 1'b0;
  endtask

  task automatic i2c_start();
    slot_active = 1'b0;
    sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b1;
    #(2*Q);
  endtask

  // Master writes a byte; slave ACK (0) or NACK (1) is queued for checking
  task automatic wbyte(input logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) sbit(d[i], 1'b0);
    exp_sda.push_back(ack ? 1'b0 : 1'b1);
    sbit(1'b1, 1'b1);
  endtask

  // Master reads a byte (expected bits queued) then sends ACK/NACK
  task automatic rbyte(input logic [7:0] d, input logic mack);
    for (int i = 7; i >= 0; i--) begin
      exp_sda.push_back(d[i]);
      sbit(1'b1, 1'b1);
    end
    sbit(mack ? 1'b0 : 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    slot_active = 1'b0; forbid_oe = 1'b0;

    fork
      // Write-strobe scoreboard and open-drain guard, sampled on negedge
      forever begin
        @(negedge clk);
        if (reg_wr_en) begin
          if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got addr %h data %h expected none", reg_addr, reg_wdata);
          end else begin
            chk("write", {reg_addr, reg_wdata}, exp_wr.pop_front());
          end
        end
        if (forbid_oe) chk("sda_oe_quiet", {15'd0, sda_oe}, 16'd0);
      end
      // SDA slot scoreboard, sampled while SCL is high
      forever begin
        @(posedge scl_m);
        #20;
        if (slot_active) begin
          if (exp_sda.size() == 0) begin
            checks++; errors++;
            $display("FAIL sda_slot: got %b expected no slot", sda_line);
          end else begin
            chk("sda_bit", {15'd0, sda_line}, {15'd0, exp_sda.pop_front()});
          end
        end
      end
    join_none

    // Reset with idle bus
    #50 reset = 1'b0;
    #50;
    chk("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
    chk("rst_wr_en", {15'd0, reg_wr_en}, 16'd0);
    chk("rst_addr", {8'd0, reg_addr}, 16'd0);
    chk("rst_wdata", {8'd0, reg_wdata}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);

    // Plain write: two bytes from pointer 3
    i2c_start();
    wbyte(8'h90, 1'b1);
    chk("busy_mid", {15'd0, busy}, 16'd1);
    wbyte(8'h03, 1'b1);
    exp_wr.push_back({8'h03, 8'hA5});
    wbyte(8'hA5, 1'b1);
    exp_wr.push_back({8'h04, 8'h5A});
    wbyte(8'h5A, 1'b1);
    i2c_stop();
    chk("busy_after_stop", {15'd0, busy}, 16'd0);

    // Pointer wrap 15 -> 0
    i2c_start();
    wbyte(8'h90, 1'b1);
    wbyte(8'h0F, 1'b1);
    exp_wr.push_back({8'h0F, 8'h11});
    wbyte(8'h11, 1'b1);
    exp_wr.push_back({8'h00, 8'h22});
    wbyte(8'h22, 1'b1);
    i2c_stop();

    // Out-of-range pointer: NACK, following byte ignored
    i2c_start();
    wbyte(8'h90, 1'b1);
    wbyte(8'h10, 1'b0);
    wbyte(8'h33, 1'b0);
    i2c_stop();

    // Pointer write then repeated-START read of two bytes
    i2c_start();
    wbyte(8'h90, 1'b1);
    wbyte(8'h02, 1'b1);
    i2c_start();
    wbyte(8'h91, 1'b1);
    rbyte(8'h42, 1'b1);
    rbyte(8'h43, 1'b0);
    chk("nack_release", {15'd0, sda_oe}, 16'd0);
    i2c_stop();
    chk("read_stop_oe", {15'd0, sda_oe}, 16'd0);

    // Address mismatch: SDA never pulled low
    forbid_oe = 1'b1;
    i2c_start();
    wbyte(8'h92, 1'b0);
    wbyte(8'h01, 1'b0);
    i2c_stop();
    forbid_oe = 1'b0;

    // STOP after 5 data bits, then a normal write
    i2c_start();
    wbyte(8'h90, 1'b1);
    wbyte(8'h05, 1'b1);
    sbit(1'b1, 1'b0); sbit(1'b0, 1'b0); sbit(1'b1, 1'b0);
    sbit(1'b1, 1'b0); sbit(1'b0, 1'b0);
    i2c_stop();
    chk("busy_partial", {15'd0, busy}, 16'd0);
    i2c_start();
    wbyte(8'h90, 1'b1);
    wbyte(8'h07, 1'b1);
    exp_wr.push_back({8'h07, 8'hC3});
    wbyte(8'hC3, 1'b1);
    i2c_stop();

    // Reset during a read byte (pointer 8 -> 0x48, bit 7 = 0 is driven)
    i2c_start();
    wbyte(8'h91, 1'b1);
    chk("read_bit7_drive", {15'd0, sda_oe}, 16'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_release", {15'd0, sda_oe}, 16'd0);
    sda_m = 1'b1; scl_m = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #100;
    chk("reset_ptr", {8'd0, reg_addr}, 16'd0);
    chk("reset_busy", {15'd0, busy}, 16'd0);

    chk("wr_queue_empty", 16'(exp_wr.size()), 16'd0);
    chk("sda_queue_empty", 16'(exp_sda.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
